// File: rtl/sq_iter.sv
// Iterative integer squarer: n*n is formed as the sum of the first n odd numbers
// (1+3+5+...). It uses a single adder, a down-counter and an enb_i/busy_o handshake.
module sq_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enb_i,
  input  logic [WIDTH-1:0]   dt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] dt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   cnt, cnt_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH:0]     odd, odd_nxt;
  logic               busy_nxt, done_nxt;
  logic [2*WIDTH-1:0] dt_nxt;

  // Next-state and datapath update; done_o defaults low so it is a one-cycle pulse
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    odd_nxt   = odd;
    busy_nxt  = busy_o;
    done_nxt  = 1'b0;
    dt_nxt    = dt_o;
    case (state)
      IDLE: begin
        if (enb_i) begin
          cnt_nxt   = dt_i;
          acc_nxt   = '0;
          odd_nxt   = (WIDTH+1)'(1);
          busy_nxt  = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (cnt != '0) begin
          // odd peaks at 2n+1, acc at (2^WIDTH-1)^2: neither can overflow
          acc_nxt = acc + {{(WIDTH-1){1'b0}}, odd};
          odd_nxt = odd + (WIDTH+1)'(2);
          cnt_nxt = cnt - WIDTH'(1);
        end else begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        dt_nxt    = acc;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any computation in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      odd    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      dt_o   <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      odd    <= odd_nxt;
      busy_o <= busy_nxt;
      done_o <= done_nxt;
      dt_o   <= dt_nxt;
    end
  end

endmodule
